// File: rtl/systolic_input_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : systolic_pkg
// Description : Shared types and constants for the systolic array front end:
//               feeder state encoding, fixed-point element type and a
//               counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int FIXED_POINT_WIDTH    = 16;
    localparam int FIXED_POINT_POSITION = 10;

    typedef logic [FIXED_POINT_WIDTH-1:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOAD_WEIGHTS = 2'd1,
        STREAM       = 2'd2,
        FLUSH        = 2'd3
    } feeder_state_t;

    // Width needed to index n items, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_input_feeder_if.sv
`default_nettype none
// ============================================================================
// Interface   : systolic_input_feeder_if
// Description : Control, weight/activation handshakes and array-side outputs
//               of the input feeder. master = tile-buffer side, slave = feeder.
// Config      : SYSTOLIC_INPUT_FEEDER_COUNT_EN adds vector_count_out.
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_input_feeder_if #(
    parameter int SYSTOLIC_ARRAY_ROWS = 8,
    parameter int SYSTOLIC_ARRAY_COLS = 8,
    parameter int FIXED_POINT_WIDTH   = 16
);
    logic                                                    start_in;
    logic                                                    busy_out;
    logic                                                    done_out;
    logic                                                    weight_valid_in;
    logic                                                    weight_ready_out;
    logic [SYSTOLIC_ARRAY_COLS-1:0][FIXED_POINT_WIDTH-1:0]   weight_row_in;
    logic                                                    act_valid_in;
    logic                                                    act_ready_out;
    logic                                                    act_last_in;
    logic [SYSTOLIC_ARRAY_ROWS-1:0][FIXED_POINT_WIDTH-1:0]   act_vector_in;
    logic                                                    weights_valid_out;
    logic [SYSTOLIC_ARRAY_COLS-1:0][FIXED_POINT_WIDTH-1:0]   weights_out;
    logic [SYSTOLIC_ARRAY_ROWS-1:0][FIXED_POINT_WIDTH-1:0]   activations_out;
    logic [SYSTOLIC_ARRAY_ROWS-1:0]                          activations_valid_out;
`ifdef SYSTOLIC_INPUT_FEEDER_COUNT_EN
    logic [15:0]                                             vector_count_out;
`endif

    modport master (
        output start_in, weight_valid_in, weight_row_in,
               act_valid_in, act_last_in, act_vector_in,
        input  busy_out, done_out, weight_ready_out, act_ready_out,
               weights_valid_out, weights_out, activations_out,
               activations_valid_out
`ifdef SYSTOLIC_INPUT_FEEDER_COUNT_EN
               , vector_count_out
`endif
    );

    modport slave (
        input  start_in, weight_valid_in, weight_row_in,
               act_valid_in, act_last_in, act_vector_in,
        output busy_out, done_out, weight_ready_out, act_ready_out,
               weights_valid_out, weights_out, activations_out,
               activations_valid_out
`ifdef SYSTOLIC_INPUT_FEEDER_COUNT_EN
               , vector_count_out
`endif
    );
endinterface
`default_nettype wire

// File: rtl/systolic_input_feeder_skew_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : skew_delay_line
// Description : DEPTH-stage shift register carrying a data word and its
//               valid flag side by side; output is the last stage.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out
);
    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0]            r_valid;

    // Shift data and valid one stage per clock.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_data  <= '0;
            r_valid <= '0;
        end else begin
            r_data[0]  <= data_in;
            r_valid[0] <= valid_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i]  <= r_data[i-1];
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    assign data_out  = r_data[DEPTH-1];
    assign valid_out = r_valid[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/systolic_input_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_input_feeder
// Description : Loads one weight tile into the array, then streams activation
//               vectors with a diagonal skew (row r delayed by r cycles) and
//               pulses done once the last skewed element has left.
// Config      : SYSTOLIC_INPUT_FEEDER_COUNT_EN adds a saturating 16-bit count
//               of accepted vectors (vector_count_out).
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_input_feeder #(
    parameter int SYSTOLIC_ARRAY_ROWS = 8,
    parameter int SYSTOLIC_ARRAY_COLS = 8,
    parameter int FIXED_POINT_WIDTH   = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    systolic_input_feeder_if.slave bus
);
    import systolic_pkg::*;

    localparam int                 c_CNT_W    = cnt_width(SYSTOLIC_ARRAY_ROWS);
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(SYSTOLIC_ARRAY_ROWS - 1);

    feeder_state_t                                         r_state;
    logic [c_CNT_W-1:0]                                    r_cnt;
    logic                                                  r_done;
    logic                                                  r_weights_valid;
    logic [SYSTOLIC_ARRAY_COLS-1:0][FIXED_POINT_WIDTH-1:0] r_weights;

    logic w_start;
    logic w_weight_fire;
    logic w_act_fire;

    // A start arriving during the done pulse is not taken: the tile is only
    // considered closed from the cycle after done.
    assign w_start       = (r_state == IDLE) && bus.start_in && !r_done;
    assign w_weight_fire = (r_state == LOAD_WEIGHTS) && bus.weight_valid_in;
    assign w_act_fire    = (r_state == STREAM) && bus.act_valid_in;

    // Tile sequencing; r_cnt counts weight rows in LOAD_WEIGHTS and drain
    // cycles in FLUSH.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_done          <= 1'b0;
            r_weights_valid <= 1'b0;
            r_weights       <= '0;
        end else begin
            r_done          <= 1'b0;
            r_weights_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= LOAD_WEIGHTS;
                        r_cnt   <= '0;
                    end
                end
                LOAD_WEIGHTS: begin
                    if (w_weight_fire) begin
                        r_weights_valid <= 1'b1;
                        r_weights       <= bus.weight_row_in;
                        if (r_cnt == c_LAST_IDX) begin
                            r_cnt   <= '0;
                            r_state <= STREAM;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                STREAM: begin
                    if (w_act_fire && bus.act_last_in) begin
                        r_state <= FLUSH;
                        r_cnt   <= '0;
                    end
                end
                FLUSH: begin
                    // ROWS drain cycles push the last vector out of row ROWS-1.
                    if (r_cnt == c_LAST_IDX) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy_out          = (r_state != IDLE);
    assign bus.done_out          = r_done;
    assign bus.weight_ready_out  = (r_state == LOAD_WEIGHTS);
    assign bus.act_ready_out     = (r_state == STREAM);
    assign bus.weights_valid_out = r_weights_valid;
    assign bus.weights_out       = r_weights;

    logic [SYSTOLIC_ARRAY_ROWS-1:0][FIXED_POINT_WIDTH-1:0] w_act_data;
    logic [SYSTOLIC_ARRAY_ROWS-1:0]                        w_act_valid;

    for (genvar r = 0; r < SYSTOLIC_ARRAY_ROWS; r++) begin : g_row
        logic [FIXED_POINT_WIDTH-1:0] w_inject;

        // Non-accepting cycles inject zero data with valid low.
        assign w_inject = w_act_fire ? bus.act_vector_in[r] : '0;

        skew_delay_line #(
            .DEPTH (r + 1),
            .WIDTH (FIXED_POINT_WIDTH)
        ) u_skew (
            .clk_in    (clk_in),
            .rst_n_in  (rst_n_in),
            .data_in   (w_inject),
            .valid_in  (w_act_fire),
            .data_out  (w_act_data[r]),
            .valid_out (w_act_valid[r])
        );
    end

    assign bus.activations_out       = w_act_data;
    assign bus.activations_valid_out = w_act_valid;

`ifdef SYSTOLIC_INPUT_FEEDER_COUNT_EN
    logic [15:0] r_vec_cnt;

    // Count accepted vectors per tile, saturating; cleared when a tile starts.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vec_cnt <= '0;
        end else if (w_start) begin
            r_vec_cnt <= '0;
        end else if (w_act_fire && (r_vec_cnt != 16'hFFFF)) begin
            r_vec_cnt <= r_vec_cnt + 16'd1;
        end
    end

    assign bus.vector_count_out = r_vec_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_input_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_input_feeder
// Description : Scoreboard bench for systolic_input_feeder at ROWS = COLS = 4.
//               Expected weight rows, skewed activations and done pulses are
//               queued with their due cycle when driven, and compared by a
//               negedge monitor.
// Config      : SYSTOLIC_INPUT_FEEDER_COUNT_EN enables the counter checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_input_feeder;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int FPW  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    systolic_input_feeder_if #(
        .SYSTOLIC_ARRAY_ROWS (ROWS),
        .SYSTOLIC_ARRAY_COLS (COLS),
        .FIXED_POINT_WIDTH   (FPW)
    ) bus ();

    systolic_input_feeder #(
        .SYSTOLIC_ARRAY_ROWS (ROWS),
        .SYSTOLIC_ARRAY_COLS (COLS),
        .FIXED_POINT_WIDTH   (FPW)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    typedef struct {
        int             due;
        logic [FPW-1:0] data;
        logic           valid;
    } act_exp_t;

    typedef struct {
        int                  due;
        logic [COLS*FPW-1:0] data;
    } w_exp_t;

    act_exp_t aq[ROWS][$];
    w_exp_t   wq[$];
    int       dq[$];

    int cyc    = 0;
    int total  = 0;
    int bad    = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Compare every output against what is due this cycle; nothing due means zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wq.size() > 0 && wq[0].due == cyc) begin
                w_exp_t we;
                we = wq.pop_front();
                check_val("weights_valid", 64'(bus.weights_valid_out), 64'd1);
                check_val("weights_data", 64'(bus.weights_out), 64'(we.data));
            end else begin
                check_val("weights_valid_idle", 64'(bus.weights_valid_out), 64'd0);
            end
            for (int r = 0; r < ROWS; r++) begin
                if (aq[r].size() > 0 && aq[r][0].due == cyc) begin
                    act_exp_t ae;
                    ae = aq[r].pop_front();
                    check_val($sformatf("act_data_r%0d", r), 64'(bus.activations_out[r]), 64'(ae.data));
                    check_val($sformatf("act_valid_r%0d", r), 64'(bus.activations_valid_out[r]), 64'(ae.valid));
                end else begin
                    check_val($sformatf("act_idle_r%0d", r),
                              {47'd0, bus.activations_valid_out[r], bus.activations_out[r]}, 64'd0);
                end
            end
            if (dq.size() > 0 && dq[0] == cyc) begin
                void'(dq.pop_front());
                check_val("done_pulse", 64'(bus.done_out), 64'd1);
                check_val("busy_at_done", 64'(bus.busy_out), 64'd0);
            end else begin
                check_val("done_idle", 64'(bus.done_out), 64'd0);
            end
        end
    end

    task automatic start_tile();
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
    endtask

    // Four weight rows on consecutive cycles; optionally offer a stray vector meanwhile.
    task automatic load_weights(input int base, input bit act_noise);
        for (int i = 0; i < ROWS; i++) begin
            w_exp_t we;
            check_val("weight_ready_in_load", 64'(bus.weight_ready_out), 64'd1);
            check_val("act_ready_in_load", 64'(bus.act_ready_out), 64'd0);
            bus.weight_valid_in = 1'b1;
            bus.weight_row_in   = mk4(base + i + 1, base + i + 1 + 16, base + i + 1 + 32, base + i + 1 + 48);
            we.due  = cyc + 1;
            we.data = bus.weight_row_in;
            wq.push_back(we);
            if (act_noise) begin
                bus.act_valid_in  = 1'b1;
                bus.act_last_in   = 1'b1;
                bus.act_vector_in = mk4(901, 902, 903, 904);
            end
            tick();
        end
        bus.weight_valid_in = 1'b0;
        bus.act_valid_in    = 1'b0;
        bus.act_last_in     = 1'b0;
        check_val("act_ready_after_load", 64'(bus.act_ready_out), 64'd1);
        check_val("weight_ready_after_load", 64'(bus.weight_ready_out), 64'd0);
    endtask

    task automatic send_vec(input logic [63:0] v, input bit last);
        logic [63:0] tmp;
        tmp = v;
        bus.act_valid_in  = 1'b1;
        bus.act_last_in   = last;
        bus.act_vector_in = tmp;
        for (int r = 0; r < ROWS; r++) begin
            act_exp_t ae;
            ae.due   = cyc + 1 + r;
            ae.data  = tmp[r*FPW +: FPW];
            ae.valid = 1'b1;
            aq[r].push_back(ae);
        end
        if (last) dq.push_back(cyc + ROWS + 1);
        tick();
        bus.act_valid_in = 1'b0;
        bus.act_last_in  = 1'b0;
    endtask

    task automatic bubble(input bit stray_start);
        for (int r = 0; r < ROWS; r++) begin
            act_exp_t ae;
            ae.due   = cyc + 1 + r;
            ae.data  = '0;
            ae.valid = 1'b0;
            aq[r].push_back(ae);
        end
        bus.start_in = stray_start;
        tick();
        bus.start_in = 1'b0;
    endtask

    // Advance to the cycle the pending done pulse is due (bounded).
    task automatic run_to_done();
        int target;
        int n;
        n = 0;
        target = (dq.size() > 0) ? dq[0] : cyc;
        while (cyc < target && n < 50) begin
            tick();
            n++;
        end
    endtask

    initial begin
        bus.start_in        = 1'b0;
        bus.weight_valid_in = 1'b0;
        bus.weight_row_in   = '0;
        bus.act_valid_in    = 1'b0;
        bus.act_last_in     = 1'b0;
        bus.act_vector_in   = '0;

        // Reset state.
        #1 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_val("reset_busy", 64'(bus.busy_out), 64'd0);
        check_val("reset_done", 64'(bus.done_out), 64'd0);
        check_val("reset_ready", {62'd0, bus.weight_ready_out, bus.act_ready_out}, 64'd0);
        check_val("reset_act", 64'(bus.activations_out), 64'd0);
`ifdef SYSTOLIC_INPUT_FEEDER_COUNT_EN
        check_val("reset_count", 64'(bus.vector_count_out), 64'd0);
`endif
        mon_en = 1'b1;
        tick();

        // Weight load with stray vectors offered, then a single skewed last vector.
        start_tile();
        check_val("busy_after_start", 64'(bus.busy_out), 64'd1);
        load_weights(0, 1'b1);
        send_vec(mk4(10, 20, 30, 40), 1'b1);
        run_to_done();
        tick();
        check_val("busy_after_tile1", 64'(bus.busy_out), 64'd0);

        // Vector, bubble (with an ignored start), last vector; start at done is ignored.
        start_tile();
        load_weights(100, 1'b0);
        send_vec(mk4(11, 12, 13, 14), 1'b0);
        bubble(1'b1);
        check_val("busy_after_stray_start", 64'(bus.busy_out), 64'd1);
        send_vec(mk4(21, 22, 23, 24), 1'b1);
        run_to_done();
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        check_val("start_at_done_ignored", 64'(bus.busy_out), 64'd0);

        // Seven back-to-back vectors.
        start_tile();
        check_val("start_after_done", 64'(bus.busy_out), 64'd1);
        load_weights(200, 1'b0);
        for (int i = 0; i < 7; i++)
            send_vec(mk4(100 + i, 200 + i, 300 + i, 400 + i), i == 6);
        run_to_done();
        tick();
`ifdef SYSTOLIC_INPUT_FEEDER_COUNT_EN
        check_val("count_after_done", 64'(bus.vector_count_out), 64'd7);
`endif
        start_tile();
`ifdef SYSTOLIC_INPUT_FEEDER_COUNT_EN
        check_val("count_cleared_on_start", 64'(bus.vector_count_out), 64'd0);
`endif

        // Reset mid-STREAM: everything clears at once and no done follows.
        load_weights(300, 1'b0);
        send_vec(mk4(31, 32, 33, 34), 1'b0);
        send_vec(mk4(41, 42, 43, 44), 1'b0);
        rst_n = 1'b0;
        wq.delete();
        dq.delete();
        for (int r = 0; r < ROWS; r++) aq[r].delete();
        #1;
        check_val("midreset_busy", 64'(bus.busy_out), 64'd0);
        check_val("midreset_done", 64'(bus.done_out), 64'd0);
        check_val("midreset_ready", {62'd0, bus.weight_ready_out, bus.act_ready_out}, 64'd0);
        check_val("midreset_act_valid", 64'(bus.activations_valid_out), 64'd0);
        check_val("midreset_act_data", 64'(bus.activations_out), 64'd0);
        check_val("midreset_wvalid", 64'(bus.weights_valid_out), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_val("post_reset_idle", 64'(bus.busy_out), 64'd0);

        check_val("queues_drained", 64'(wq.size() + dq.size() + aq[0].size() + aq[1].size()
                                        + aq[2].size() + aq[3].size()), 64'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
